i2c_slave_if: RTL and testbench
===============================

# i2c_slave_if

Synthesizable I2C slave responder/monitor attached to one I2C bus segment of the multi-bus controller test environment. It oversamples SCL/SDA on the system clock, detects START/STOP, acknowledges every address and write byte, and reports captured transfers on a simple pulse interface. On reads it sources an incrementing byte sequence. It never stretches the clock.

## Interface
- I2C_ADDR_WIDTH, 7, slave address width
- I2C_DATA_WIDTH, 8, data byte width
- READ_START, 8'd100, first byte returned in each read transfer

- clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- scl_i  in  1  I2C clock from bus (resolved wired-AND)
- sda_i  in  1  I2C data from bus
- scl_o  out  1  open-drain clock drive; constant 1 (released)
- sda_o  out  1  open-drain data drive; 0 = pull low, 1 = release
- busy_o  out  1  high from START until STOP
- op_o  out  1  i2c_op_t of current/last transfer (0 write, 1 read)
- addr_o  out  I2C_ADDR_WIDTH  address of current/last transfer
- data_o  out  I2C_DATA_WIDTH  last byte written by master
- data_valid_o  out  1  one-cycle pulse when data_o updates
- done_o  out  1  one-cycle pulse at STOP or repeated START ending a transfer
- count_o  out  8  data bytes in finished transfer; valid with done_o

## Operation
- SCL/SDA pass through 2-flop synchronizers; edges detected on synchronized values.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both recognized in any state.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE -> ADDR on START. ADDR shifts 8 bits MSB-first on SCL rise; bits[7:1] -> addr_o, bit0 -> op_o.
- ADDR_ACK: after 8th SCL fall drive sda_o=0 for ninth clock; release after ninth fall. Any address is acknowledged. Next: WR_DATA (op=0) or RD_DATA (op=1, counter loaded with READ_START, first bit driven).
- WR_DATA: shift 8 bits; on 8th rise update data_o, pulse data_valid_o, count_o++; then WR_ACK (drive 0 for ninth clock) -> WR_DATA.
- RD_DATA: drive counter bit MSB-first, changing only after SCL fall; after 8 bits release SDA -> RD_ACK. Sample master ACK on ninth rise: ACK (0) -> counter++ (8-bit wrap 255->0), count_o++, next byte; NACK -> count_o++, WAIT_STOP (SDA released).
- STOP in any non-IDLE state: pulse done_o, release SDA, -> IDLE. Partial bytes discarded, not counted.
- Repeated START in non-IDLE state: pulse done_o for old transfer, clear byte count, -> ADDR.
- Reset mid-transfer: immediate IDLE, SDA released, no done_o.

## Timing
- Reset values: scl_o=1, sda_o=1, busy_o=0, op_o=0, addr_o=0, data_o=0, data_valid_o=0, done_o=0, count_o=0.
- Detection latency: 3 clk_i cycles from raw pin edge to state action (2 sync + 1 edge register).
- sda_o changes one cycle after detected SCL fall; never changes while synchronized SCL high.
- data_valid_o asserts cycle after detected 8th SCL rise; done_o asserts cycle after STOP/START detection.
- clk_i must be >= 16x SCL frequency.

## Structure
- Package i2c_pkg: i2c_op_t (I2C_WRITE=0, I2C_READ=1), state enum, width constants.
- Sub-module i2c_sync_edge: 2-flop synchronizer plus rise/fall detect, instantiated for SCL and SDA.
- Top: FSM, bit counter (0..8), shift register, read counter.

## Test plan
- Write addr 0x22, one byte 0x78, STOP -> addr_o=0x22, op_o=0, data_o=0x78 one data_valid_o pulse, SDA low on both ninth clocks, done_o with count_o=1.
- Write 32 bytes 0x00..0x1F to addr 0x22 -> 32 data_valid_o pulses in order, count_o=32.
- Read 32 bytes from 0x22, ACK first 31, NACK last -> master receives 100..131, count_o=32, SDA released after NACK.
- Write 2 bytes, repeated START, read 1 byte -> done_o with count_o=2, then op_o=1, master gets 100, done_o count_o=1 at STOP.
- STOP after 4 bits of a write byte -> no data_valid_o, done_o with prior count.
- rst_i asserted during RD_DATA with SDA driven low -> sda_o=1 next cycle, busy_o=0, no done_o.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave responder/monitor.
//   i2c_op_t   : transfer direction taken from the address byte LSB
//   state_t    : FSM state encoding plus its named constants
//   shift_in() : MSB-first shift helper used by the address and write paths
package i2c_pkg;

    localparam int unsigned I2C_ADDR_WIDTH = 7;
    localparam int unsigned I2C_DATA_WIDTH = 8;
    localparam logic [I2C_DATA_WIDTH-1:0] READ_START = 8'd100;

    typedef enum logic {
        I2C_WRITE = 1'b0,
        I2C_READ  = 1'b1
    } i2c_op_t;

    typedef logic [2:0] state_t;

    localparam state_t StIdle     = 3'd0;
    localparam state_t StAddr     = 3'd1;
    localparam state_t StAddrAck  = 3'd2;
    localparam state_t StWrData   = 3'd3;
    localparam state_t StWrAck    = 3'd4;
    localparam state_t StRdData   = 3'd5;
    localparam state_t StRdAck    = 3'd6;
    localparam state_t StWaitStop = 3'd7;

    function automatic logic [I2C_DATA_WIDTH-1:0] shift_in(
        input logic [I2C_DATA_WIDTH-1:0] cur,
        input logic                      b
    );
        return {cur[I2C_DATA_WIDTH-2:0], b};
    endfunction

endpackage

// File: rtl/i2c_slave_if_if.sv
// Bus bundle between the I2C segment / test environment and the slave.
//   scl_i, sda_i : resolved bus levels seen by the slave
//   scl_o, sda_o : open-drain drives from the slave (1 = released)
//   busy_o, op_o, addr_o, data_o, data_valid_o, done_o, count_o : transfer report
// The slave modport is used by the DUT; the master modport by the environment.
interface i2c_slave_if_if;
    import i2c_pkg::*;

    logic                      scl_i;
    logic                      sda_i;
    logic                      scl_o;
    logic                      sda_o;
    logic                      busy_o;
    i2c_op_t                   op_o;
    logic [I2C_ADDR_WIDTH-1:0] addr_o;
    logic [I2C_DATA_WIDTH-1:0] data_o;
    logic                      data_valid_o;
    logic                      done_o;
    logic [7:0]                count_o;

    modport slave (
        input  scl_i, sda_i,
        output scl_o, sda_o, busy_o, op_o, addr_o, data_o, data_valid_o, done_o, count_o
    );

    modport master (
        output scl_i, sda_i,
        input  scl_o, sda_o, busy_o, op_o, addr_o, data_o, data_valid_o, done_o, count_o
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer followed by an edge register for one bus line.
//   clk_i, rst_i : system clock, synchronous active-high reset
//   d_i          : asynchronous bus line
//   level_o      : synchronized level
//   rise_o/fall_o: single-cycle edge strobes on the synchronized level
// Flops reset to 1 since an idle I2C line is pulled high.
module i2c_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_slave_if.sv
// I2C slave responder/monitor for one bus segment.
//   clk_i  : system clock (>= 16x SCL)
//   rst_i  : synchronous active-high reset
//   bus_io : slave modport carrying SCL/SDA in/out and the transfer report
// Acknowledges every address and write byte, sources an incrementing byte
// sequence on reads, never stretches SCL.
module i2c_slave_if
    import i2c_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    i2c_slave_if_if.slave  bus_io
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (bus_io.scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (bus_io.sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    state_t                    state_q, state_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [I2C_DATA_WIDTH-1:0] shift_q, shift_d;
    logic [I2C_DATA_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [7:0]                byte_cnt_q, byte_cnt_d;
    logic [7:0]                count_q, count_d;
    logic                      sda_q, sda_d;
    logic                      busy_q, busy_d;
    i2c_op_t                   op_q, op_d;
    logic [I2C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [I2C_DATA_WIDTH-1:0] data_q, data_d;
    logic                      data_valid_q, data_valid_d;
    logic                      done_q, done_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rd_cnt_d     = rd_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        count_d      = count_q;
        sda_d        = sda_q;
        busy_d       = busy_q;
        op_d         = op_q;
        addr_d       = addr_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        done_d       = 1'b0;

        if (sda_rise && scl_lvl && (state_q != StIdle)) begin
            // STOP: close the transfer, any partial byte is dropped
            done_d  = 1'b1;
            count_d = byte_cnt_q;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
        end else if (sda_fall && scl_lvl) begin
            // START or repeated START; a repeated one closes the old transfer
            if (state_q != StIdle) begin
                done_d  = 1'b1;
                count_d = byte_cnt_q;
            end
            byte_cnt_d = 8'd0;
            bit_cnt_d  = 4'd0;
            sda_d      = 1'b1;
            busy_d     = 1'b1;
            state_d    = StAddr;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise && (bit_cnt_q != 4'd8)) begin
                        shift_d   = shift_in(shift_q, sda_lvl);
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            addr_d = shift_d[I2C_DATA_WIDTH-1:1];
                            op_d   = i2c_op_t'(shift_d[0]);
                        end
                    end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                        sda_d     = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = StAddrAck;
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (op_q == I2C_READ) begin
                            rd_cnt_d = READ_START;
                            sda_d    = READ_START[I2C_DATA_WIDTH-1];
                            state_d  = StRdData;
                        end else begin
                            sda_d   = 1'b1;
                            state_d = StWrData;
                        end
                    end
                end
                StWrData: begin
                    if (scl_rise && (bit_cnt_q != 4'd8)) begin
                        shift_d   = shift_in(shift_q, sda_lvl);
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            data_d       = shift_d;
                            data_valid_d = 1'b1;
                            byte_cnt_d   = byte_cnt_q + 8'd1;
                        end
                    end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                        sda_d     = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = StWrAck;
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        sda_d   = 1'b1;
                        state_d = StWrData;
                    end
                end
                StRdData: begin
                    if (scl_rise && (bit_cnt_q != 4'd8)) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_d   = 1'b1;
                            state_d = StRdAck;
                        end else if (bit_cnt_q != 4'd0) begin
                            // bit_cnt_q bits already clocked out, present the next one
                            sda_d = rd_cnt_q[3'd7 - bit_cnt_q[2:0]];
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        if (sda_lvl) begin
                            state_d = StWaitStop;
                        end else begin
                            rd_cnt_d = rd_cnt_q + 8'd1;
                        end
                    end else if (scl_fall) begin
                        // only reachable after an ACK rise; start the next byte
                        sda_d     = rd_cnt_q[I2C_DATA_WIDTH-1];
                        bit_cnt_d = 4'd0;
                        state_d   = StRdData;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            rd_cnt_q     <= '0;
            byte_cnt_q   <= 8'd0;
            count_q      <= 8'd0;
            sda_q        <= 1'b1;
            busy_q       <= 1'b0;
            op_q         <= I2C_WRITE;
            addr_q       <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rd_cnt_q     <= rd_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            count_q      <= count_d;
            sda_q        <= sda_d;
            busy_q       <= busy_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            done_q       <= done_d;
        end
    end

    assign bus_io.scl_o        = 1'b1;
    assign bus_io.sda_o        = sda_q;
    assign bus_io.busy_o       = busy_q;
    assign bus_io.op_o         = op_q;
    assign bus_io.addr_o       = addr_q;
    assign bus_io.data_o       = data_q;
    assign bus_io.data_valid_o = data_valid_q;
    assign bus_io.done_o       = done_q;
    assign bus_io.count_o      = count_q;

endmodule

// File: tb/tb_i2c_slave_if.sv
module tb_i2c_slave_if;
    import i2c_pkg::*;

    localparam int Q = 5;  // clk cycles per quarter SCL period

    logic clk;
    logic rst;
    logic scl_m;
    logic sda_m;

    i2c_slave_if_if bus ();

    assign bus.scl_i = scl_m & bus.scl_o;
    assign bus.sda_i = sda_m & bus.sda_o;

    i2c_slave_if dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_done;
        logic [7:0] val;
        logic [6:0] addr;
        logic       op;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_dv(input logic [7:0] d, input logic [6:0] a);
        exp_q.push_back('{is_done: 1'b0, val: d, addr: a, op: 1'b0});
    endtask

    task automatic push_done(input logic [7:0] c);
        exp_q.push_back('{is_done: 1'b1, val: c, addr: 7'h0, op: 1'b0});
    endtask

    // Scoreboard monitor: pops one expectation per DUT report pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.data_valid_o) begin
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    chk("unexpected_data_valid", {24'h0, bus.data_o}, 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_o", {24'h0, bus.data_o}, {24'h0, e.val});
                    chk("dv_addr_o", {25'h0, bus.addr_o}, {25'h0, e.addr});
                    chk("dv_op_o", {31'h0, bus.op_o}, {31'h0, e.op});
                end
            end
            if (bus.done_o) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    chk("unexpected_done", {24'h0, bus.count_o}, 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("count_o", {24'h0, bus.count_o}, {24'h0, e.val});
                end
            end
        end
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        r = bus.sda_i;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
        logic r;
        d = 8'h0;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, r);
            d = {d[6:0], r};
        end
        bit_xfer(ack_bit, r);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        checks = 0;
        errors = 0;
        scl_m  = 1'b1;
        sda_m  = 1'b1;
        rst    = 1'b1;
        wait_clk(5);

        chk("rst_scl_o", {31'h0, bus.scl_o}, 32'h1);
        chk("rst_sda_o", {31'h0, bus.sda_o}, 32'h1);
        chk("rst_busy_o", {31'h0, bus.busy_o}, 32'h0);
        chk("rst_op_o", {31'h0, bus.op_o}, 32'h0);
        chk("rst_addr_o", {25'h0, bus.addr_o}, 32'h0);
        chk("rst_data_o", {24'h0, bus.data_o}, 32'h0);
        chk("rst_data_valid_o", {31'h0, bus.data_valid_o}, 32'h0);
        chk("rst_done_o", {31'h0, bus.done_o}, 32'h0);
        chk("rst_count_o", {24'h0, bus.count_o}, 32'h0);
        rst = 1'b0;
        wait_clk(10);

        // single-byte write
        i2c_start();
        chk("t1_busy", {31'h0, bus.busy_o}, 32'h1);
        send_byte({7'h22, 1'b0}, ack);
        chk("t1_addr_ack", {31'h0, ack}, 32'h0);
        push_dv(8'h78, 7'h22);
        send_byte(8'h78, ack);
        chk("t1_data_ack", {31'h0, ack}, 32'h0);
        push_done(8'd1);
        i2c_stop();
        chk("t1_addr_o", {25'h0, bus.addr_o}, 32'h22);
        chk("t1_op_o", {31'h0, bus.op_o}, 32'h0);
        chk("t1_busy_end", {31'h0, bus.busy_o}, 32'h0);
        wait_clk(10);

        // 32-byte write
        i2c_start();
        send_byte({7'h22, 1'b0}, ack);
        chk("t2_addr_ack", {31'h0, ack}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            push_dv(8'(i), 7'h22);
            send_byte(8'(i), ack);
            chk("t2_data_ack", {31'h0, ack}, 32'h0);
        end
        push_done(8'd32);
        i2c_stop();
        wait_clk(10);

        // 32-byte read, NACK on the last
        i2c_start();
        send_byte({7'h22, 1'b1}, ack);
        chk("t3_addr_ack", {31'h0, ack}, 32'h0);
        chk("t3_addr_o", {25'h0, bus.addr_o}, 32'h22);
        chk("t3_op_o", {31'h0, bus.op_o}, 32'h1);
        for (int i = 0; i < 32; i++) begin
            recv_byte((i == 31) ? 1'b1 : 1'b0, d);
            chk("t3_rd_byte", {24'h0, d}, 32'(100 + i));
        end
        chk("t3_sda_released", {31'h0, bus.sda_o}, 32'h1);
        push_done(8'd32);
        i2c_stop();
        wait_clk(10);

        // write 2, repeated START, read 1
        i2c_start();
        send_byte({7'h22, 1'b0}, ack);
        chk("t4_addr_ack", {31'h0, ack}, 32'h0);
        push_dv(8'hA5, 7'h22);
        send_byte(8'hA5, ack);
        push_dv(8'h3C, 7'h22);
        send_byte(8'h3C, ack);
        chk("t4_data_ack", {31'h0, ack}, 32'h0);
        push_done(8'd2);
        i2c_start();
        send_byte({7'h22, 1'b1}, ack);
        chk("t4_rd_addr_ack", {31'h0, ack}, 32'h0);
        chk("t4_op_o", {31'h0, bus.op_o}, 32'h1);
        recv_byte(1'b1, d);
        chk("t4_rd_byte", {24'h0, d}, 32'd100);
        push_done(8'd1);
        i2c_stop();
        wait_clk(10);

        // STOP after a partial byte
        i2c_start();
        send_byte({7'h22, 1'b0}, ack);
        push_dv(8'h5A, 7'h22);
        send_byte(8'h5A, ack);
        chk("t5_data_ack", {31'h0, ack}, 32'h0);
        bit_xfer(1'b1, ack);
        bit_xfer(1'b0, ack);
        bit_xfer(1'b1, ack);
        bit_xfer(1'b0, ack);
        push_done(8'd1);
        i2c_stop();
        chk("t5_data_o_kept", {24'h0, bus.data_o}, 32'h5A);
        wait_clk(10);

        // reset while the slave drives the first read bit (100 = 0b0110_0100) low
        i2c_start();
        send_byte({7'h22, 1'b1}, ack);
        chk("t6_addr_ack", {31'h0, ack}, 32'h0);
        chk("t6_sda_low", {31'h0, bus.sda_o}, 32'h0);
        rst = 1'b1;
        wait_clk(1);
        chk("t6_sda_released", {31'h0, bus.sda_o}, 32'h1);
        chk("t6_busy", {31'h0, bus.busy_o}, 32'h0);
        chk("t6_done", {31'h0, bus.done_o}, 32'h0);
        rst = 1'b0;
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(50);

        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
